pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and flow-control unit for the 5-stage in-order pipeline; successor to the free-running flow, which has no stall, flush or forwarding.
- Tracks in-flight register writers in a shift scoreboard (EX..WB) and detects RAW hazards against the instruction in ID.
- Produces forwarding selects, stall and bubble controls for the pipeline registers, and branch-redirect flushes.
- Keeps saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 5, register address width; register 0 is hard-wired zero and never tracked
DEPTH, 3, scoreboard entries; entry 0 = EX, entry DEPTH-1 = last stage before regfile write
LOAD_LAT, 1, a load in entry k is forwardable only if k >= LOAD_LAT
FWD_EN, 1, 1 = forwarding enabled; 0 = stall on any match
FLUSH_ENTRIES, 1, youngest scoreboard entries invalidated on redirect (1..DEPTH)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
id_uses_rs1, id_uses_rs2  in  1  source actually read
id_rd  in  REG_ADDR_W  ID destination register
id_reg_write  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
redirect  in  1  branch taken, resolved in MEM (PCSrc)
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_id  out  1  bubble into IF/ID
flush_ex  out  1  bubble into ID/EX
flush_mem  out  1  bubble into EX/MEM
fwd_rs1_sel, fwd_rs2_sel  out  $clog2(DEPTH+1)  0 = regfile; k+1 = result of entry k
stall_cnt  out  CNT_W  cycles with load/RAW stall asserted
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Scoreboard entry = {valid, rd, is_load}; the only state besides the two counters.
- Reset (reset=0, async): all entries invalid; both counters 0. Consequently stall_*, flush_* and fwd_* are all 0 while in reset.
- Match for a source: id_valid && uses && entry.valid && entry.rd == rs && rs != 0.
- Each source takes the youngest matching entry (smallest k); older matches are ignored.
- With FWD_EN=1, a youngest match is forwardable iff !is_load || k >= LOAD_LAT.
  - Forwardable: sel = k+1.
  - Not forwardable: hazard.
  - No match: sel = 0.
- With FWD_EN=0, any match is a hazard and sel is always 0.
- hazard = (rs1 hazard || rs2 hazard) && !redirect.
- Outputs are combinational from scoreboard + ID inputs + redirect (0-cycle latency):
  - stall_if = stall_id = flush_ex = hazard.
  - flush_id = flush_mem = redirect. flush_ex is also 1 on redirect.
- Scoreboard update at the clock edge:
  - Shift: entry k+1 <= entry k; entry DEPTH-1 retires.
  - If redirect: entries 0..FLUSH_ENTRIES-1 are invalidated before the shift, and an invalid entry is shifted into entry 0.
  - Else if hazard: invalid entry (bubble) shifted into entry 0.
  - Else: entry 0 <= {id_valid && id_reg_write && id_rd!=0, id_rd, id_is_load}.
- Redirect and hazard in the same cycle: redirect wins; no stall, no stall_cnt increment.
- stall_cnt increments on each hazard cycle; flush_cnt increments on each redirect cycle.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- rd=0 writers are never entered. rs=0 never matches.
- sel width is computed with DEPTH+1 so DEPTH=1 still yields a 1-bit select.

Decomposition:
- pipeline_flow package gains:
  - sb_entry_t (valid, rd, is_load);
  - fwd_sel_t;
  - hazard_ctrl_t, a bundle of stall_if, stall_id, flush_id, flush_ex, flush_mem.
- One sub-module: hazard_src_match, instantiated twice (rs1, rs2).
  - Inputs: scoreboard vector, rs, uses.
  - Outputs: sel, hazard.
  - Contains the youngest-match priority and the forwardability check.

Test Plan:
- Back-to-back ALU RAW: addi x5 issued, next cycle add x6,x5,x5 in ID -> fwd_rs1_sel=fwd_rs2_sel=1, no stall; one cycle later an x5 reader gets sel=2.
- Load-use, LOAD_LAT=1: lw x7 then add x8,x7,x0 -> stall_if=stall_id=flush_ex=1 for exactly 1 cycle, then sel=2; stall_cnt=1.
- Redirect over a hazard: redirect=1 in the same cycle as a load-use hazard -> stall 0, flush_id=flush_ex=flush_mem=1; entry 0 invalidated; flush_cnt=1, stall_cnt unchanged.
- Youngest priority: x3 written by entries 2 and 0 -> sel=1; with FWD_EN=0 -> stall every cycle until x3 has left all DEPTH entries, i.e. 3 stall cycles for DEPTH=3.
- x0 and unused sources: rd=0 writer, then reader of x0, then id_uses_rs1=0 on a matching rs1 -> sel=0, no stall.
- Saturation and async reset: CNT_W=4, 20 hazard cycles -> stall_cnt=15. Assert reset mid-stall -> outputs 0 immediately, before the next edge; counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/flow-control unit: scoreboard entries,
// forwarding selects and the pipeline-register control bundle.
package pipe_hazard_ctrl_pkg;

    // Widest register address and select the shared types can carry; narrower
    // instances zero-extend into them.
    localparam int unsigned RD_W_MAX  = 8;
    localparam int unsigned SEL_W_MAX = 4;

    typedef logic [RD_W_MAX-1:0]  sb_rd_t;
    typedef logic [SEL_W_MAX-1:0] fwd_sel_t;

    typedef struct packed {
        logic   valid;
        sb_rd_t rd;
        logic   is_load;
    } sb_entry_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
    } hazard_ctrl_t;

endpackage

// File: rtl/hazard_src_match.sv
// Per-source RAW lookup: picks the youngest matching in-flight writer and
// decides between forwarding from it or raising a hazard.
module hazard_src_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned SEL_W    = 2
) (
    input  sb_entry_t [DEPTH-1:0] sb_i,
    input  sb_rd_t                rs_i,
    input  logic                  uses_i,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  hazard_o
);

    logic found;

    always_comb begin
        sel_o    = '0;
        hazard_o = 1'b0;
        found    = 1'b0;
        // Entry 0 is the youngest writer, so the first hit wins.
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && uses_i && (rs_i != '0) && sb_i[k].valid && (sb_i[k].rd == rs_i)) begin
                found = 1'b1;
                if ((FWD_EN != 0) && (!sb_i[k].is_load || (k >= LOAD_LAT))) begin
                    sel_o = SEL_W'(k + 1);
                end else begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow-control unit for the 5-stage pipeline: writer scoreboard,
// forwarding selects, stall/bubble/flush controls and saturating perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter  int unsigned REG_ADDR_W    = 5,
    parameter  int unsigned DEPTH         = 3,
    parameter  int unsigned LOAD_LAT      = 1,
    parameter  int unsigned FWD_EN        = 1,
    parameter  int unsigned FLUSH_ENTRIES = 1,
    parameter  int unsigned CNT_W         = 16,
    localparam int unsigned SEL_W         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  redirect,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic                  flush_mem,
    output logic [SEL_W-1:0]      fwd_rs1_sel,
    output logic [SEL_W-1:0]      fwd_rs2_sel,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    sb_entry_t [DEPTH-1:0] sb_q, sb_d, sb_flt;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                  haz_rs1, haz_rs2, hazard, redirect_eff;
    hazard_ctrl_t          ctrl;

    // Gated so no flush escapes while the unit is held in reset.
    assign redirect_eff = redirect & reset;

    hazard_src_match #(
        .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN), .SEL_W(SEL_W)
    ) u_match_rs1 (
        .sb_i    (sb_q),
        .rs_i    (sb_rd_t'(id_rs1)),
        .uses_i  (id_valid & id_uses_rs1),
        .sel_o   (fwd_rs1_sel),
        .hazard_o(haz_rs1)
    );

    hazard_src_match #(
        .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN), .SEL_W(SEL_W)
    ) u_match_rs2 (
        .sb_i    (sb_q),
        .rs_i    (sb_rd_t'(id_rs2)),
        .uses_i  (id_valid & id_uses_rs2),
        .sel_o   (fwd_rs2_sel),
        .hazard_o(haz_rs2)
    );

    assign hazard = (haz_rs1 | haz_rs2) & ~redirect_eff;

    always_comb begin
        ctrl.stall_if  = hazard;
        ctrl.stall_id  = hazard;
        ctrl.flush_id  = redirect_eff;
        ctrl.flush_ex  = hazard | redirect_eff;
        ctrl.flush_mem = redirect_eff;
    end

    assign stall_if  = ctrl.stall_if;
    assign stall_id  = ctrl.stall_id;
    assign flush_id  = ctrl.flush_id;
    assign flush_ex  = ctrl.flush_ex;
    assign flush_mem = ctrl.flush_mem;

    always_comb begin
        sb_flt = sb_q;
        if (redirect_eff) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k < FLUSH_ENTRIES) sb_flt[k].valid = 1'b0;
            end
        end
        sb_d = '0;
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_flt[k-1];
        end
        if (!redirect_eff && !hazard) begin
            sb_d[0].valid   = id_valid & id_reg_write & (id_rd != '0);
            sb_d[0].rd      = sb_rd_t'(id_rd);
            sb_d[0].is_load = id_is_load;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && (stall_cnt_q != '1))       stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (redirect_eff && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
